id_ex_register: RTL and testbench



---
 rtl/id_ex_register_pkg.sv | 43 ++++
 rtl/id_ex_register_sat_counter.sv | 33 +++
 rtl/id_ex_register.sv | 126 ++++++++++++
 tb/tb_id_ex_register.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_register_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALUOp classes, control
// bundle layout, default widths and the bubble constant.
package id_ex_register_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      ALUOP_LDST   = 2'b00,
      ALUOP_BRANCH = 2'b01,
      ALUOP_RTYPE  = 2'b10,
      ALUOP_ITYPE  = 2'b11
   } aluop_e;

   // Everything a bubble must clear travels in this one bundle (MSB first).
   typedef struct packed {
      logic       valid;
      logic       regwrite;
      logic       memtoreg;
      logic       memread;
      logic       memwrite;
      logic       alusrc;
      logic [1:0] aluop;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } ctrl_t;

   localparam int unsigned CTRL_W            = $bits(ctrl_t);
   localparam int unsigned CTRL_RD_LSB       = 0;
   localparam int unsigned CTRL_RS2_LSB      = 5;
   localparam int unsigned CTRL_RS1_LSB      = 10;
   localparam int unsigned CTRL_ALUOP_LSB    = 15;
   localparam int unsigned CTRL_ALUSRC_BIT   = 17;
   localparam int unsigned CTRL_MEMWRITE_BIT = 18;
   localparam int unsigned CTRL_MEMREAD_BIT  = 19;
   localparam int unsigned CTRL_MEMTOREG_BIT = 20;
   localparam int unsigned CTRL_REGWRITE_BIT = 21;
   localparam int unsigned CTRL_VALID_BIT    = 22;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_register_sat_counter.sv
// Saturating up-counter used for the ID/EX performance counters.
module sat_counter
   import id_ex_register_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: loads decoded ID state, inserts bubbles on hazard
// request, freezes on data-cache stall, and counts bubbles/stall cycles.
module id_ex_register
   import id_ex_register_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              MemStall_i,
   input  logic              NoOp_i,
   input  logic              ID_valid_i,
   input  logic              ID_RegWrite_i,
   input  logic              ID_MemtoReg_i,
   input  logic              ID_MemRead_i,
   input  logic              ID_MemWrite_i,
   input  logic              ID_ALUSrc_i,
   input  logic [1:0]        ID_ALUOp_i,
   input  logic [DATA_W-1:0] ID_RS1data_i,
   input  logic [DATA_W-1:0] ID_RS2data_i,
   input  logic [DATA_W-1:0] ID_Imm_i,
   input  logic [9:0]        ID_funct_i,
   input  logic [4:0]        ID_rs1_i,
   input  logic [4:0]        ID_rs2_i,
   input  logic [4:0]        ID_rd_i,
   output logic              EX_valid_o,
   output logic              EX_RegWrite_o,
   output logic              EX_MemtoReg_o,
   output logic              EX_MemRead_o,
   output logic              EX_MemWrite_o,
   output logic              EX_ALUSrc_o,
   output logic [1:0]        EX_ALUOp_o,
   output logic [DATA_W-1:0] EX_RS1data_o,
   output logic [DATA_W-1:0] EX_RS2data_o,
   output logic [DATA_W-1:0] EX_Imm_o,
   output logic [9:0]        EX_funct_o,
   output logic [4:0]        EX_rs1_o,
   output logic [4:0]        EX_rs2_o,
   output logic [4:0]        EX_rd_o,
   output logic [CNT_W-1:0]  bubble_cnt_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   ctrl_t             ctrl_q, ctrl_d, ctrl_id;
   logic [DATA_W-1:0] rs1data_q, rs1data_d;
   logic [DATA_W-1:0] rs2data_q, rs2data_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [9:0]        funct_q, funct_d;
   logic              bubble;

   assign ctrl_id = '{valid:    ID_valid_i,
                      regwrite: ID_RegWrite_i,
                      memtoreg: ID_MemtoReg_i,
                      memread:  ID_MemRead_i,
                      memwrite: ID_MemWrite_i,
                      alusrc:   ID_ALUSrc_i,
                      aluop:    ID_ALUOp_i,
                      rs1:      ID_rs1_i,
                      rs2:      ID_rs2_i,
                      rd:       ID_rd_i};

   assign bubble = !MemStall_i && NoOp_i;

   always_comb begin
      ctrl_d    = ctrl_q;
      rs1data_d = rs1data_q;
      rs2data_d = rs2data_q;
      imm_d     = imm_q;
      funct_d   = funct_q;
      if (!MemStall_i) begin
         // Clearing memread/rd here lets the hazard compare drop next cycle.
         ctrl_d    = NoOp_i ? CTRL_BUBBLE : ctrl_id;
         rs1data_d = NoOp_i ? '0 : ID_RS1data_i;
         rs2data_d = NoOp_i ? '0 : ID_RS2data_i;
         imm_d     = NoOp_i ? '0 : ID_Imm_i;
         funct_d   = NoOp_i ? '0 : ID_funct_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ctrl_q    <= CTRL_BUBBLE;
         rs1data_q <= '0;
         rs2data_q <= '0;
         imm_q     <= '0;
         funct_q   <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         rs1data_q <= rs1data_d;
         rs2data_q <= rs2data_d;
         imm_q     <= imm_d;
         funct_q   <= funct_d;
      end
   end

   assign EX_valid_o    = ctrl_q.valid;
   assign EX_RegWrite_o = ctrl_q.regwrite;
   assign EX_MemtoReg_o = ctrl_q.memtoreg;
   assign EX_MemRead_o  = ctrl_q.memread;
   assign EX_MemWrite_o = ctrl_q.memwrite;
   assign EX_ALUSrc_o   = ctrl_q.alusrc;
   assign EX_ALUOp_o    = ctrl_q.aluop;
   assign EX_rs1_o      = ctrl_q.rs1;
   assign EX_rs2_o      = ctrl_q.rs2;
   assign EX_rd_o       = ctrl_q.rd;
   assign EX_RS1data_o  = rs1data_q;
   assign EX_RS2data_o  = rs2data_q;
   assign EX_Imm_o      = imm_q;
   assign EX_funct_o    = funct_q;

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (bubble),
      .count_o (bubble_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (MemStall_i),
      .count_o (stall_cnt_o)
   );

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register against a snapshot-level reference model.
module tb_id_ex_register;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned VEC_W   = 129;
   localparam int          CNT_MAX = 65535;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic              MemStall_i = 1'b0;
   logic              NoOp_i = 1'b0;
   logic              ID_valid_i = 1'b0;
   logic              ID_RegWrite_i = 1'b0;
   logic              ID_MemtoReg_i = 1'b0;
   logic              ID_MemRead_i = 1'b0;
   logic              ID_MemWrite_i = 1'b0;
   logic              ID_ALUSrc_i = 1'b0;
   logic [1:0]        ID_ALUOp_i = '0;
   logic [DATA_W-1:0] ID_RS1data_i = '0;
   logic [DATA_W-1:0] ID_RS2data_i = '0;
   logic [DATA_W-1:0] ID_Imm_i = '0;
   logic [9:0]        ID_funct_i = '0;
   logic [4:0]        ID_rs1_i = '0;
   logic [4:0]        ID_rs2_i = '0;
   logic [4:0]        ID_rd_i = '0;
   logic              EX_valid_o, EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o;
   logic              EX_MemWrite_o, EX_ALUSrc_o;
   logic [1:0]        EX_ALUOp_o;
   logic [DATA_W-1:0] EX_RS1data_o, EX_RS2data_o, EX_Imm_o;
   logic [9:0]        EX_funct_o;
   logic [4:0]        EX_rs1_o, EX_rs2_o, EX_rd_o;
   logic [CNT_W-1:0]  bubble_cnt_o, stall_cnt_o;

   int checks = 0;
   int errors = 0;

   // Reference model: the whole EX side as one snapshot plus two integer counts.
   logic [VEC_W-1:0] m_ex = '0;
   int               m_bub = 0;
   int               m_stall = 0;

   id_ex_register #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .MemStall_i(MemStall_i), .NoOp_i(NoOp_i),
      .ID_valid_i(ID_valid_i), .ID_RegWrite_i(ID_RegWrite_i),
      .ID_MemtoReg_i(ID_MemtoReg_i), .ID_MemRead_i(ID_MemRead_i),
      .ID_MemWrite_i(ID_MemWrite_i), .ID_ALUSrc_i(ID_ALUSrc_i),
      .ID_ALUOp_i(ID_ALUOp_i), .ID_RS1data_i(ID_RS1data_i),
      .ID_RS2data_i(ID_RS2data_i), .ID_Imm_i(ID_Imm_i), .ID_funct_i(ID_funct_i),
      .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i), .ID_rd_i(ID_rd_i),
      .EX_valid_o(EX_valid_o), .EX_RegWrite_o(EX_RegWrite_o),
      .EX_MemtoReg_o(EX_MemtoReg_o), .EX_MemRead_o(EX_MemRead_o),
      .EX_MemWrite_o(EX_MemWrite_o), .EX_ALUSrc_o(EX_ALUSrc_o),
      .EX_ALUOp_o(EX_ALUOp_o), .EX_RS1data_o(EX_RS1data_o),
      .EX_RS2data_o(EX_RS2data_o), .EX_Imm_o(EX_Imm_o), .EX_funct_o(EX_funct_o),
      .EX_rs1_o(EX_rs1_o), .EX_rs2_o(EX_rs2_o), .EX_rd_o(EX_rd_o),
      .bubble_cnt_o(bubble_cnt_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [VEC_W-1:0] id_vec();
      return {ID_valid_i, ID_RegWrite_i, ID_MemtoReg_i, ID_MemRead_i, ID_MemWrite_i,
              ID_ALUSrc_i, ID_ALUOp_i, ID_RS1data_i, ID_RS2data_i, ID_Imm_i,
              ID_funct_i, ID_rs1_i, ID_rs2_i, ID_rd_i};
   endfunction

   function automatic logic [VEC_W-1:0] ex_vec();
      return {EX_valid_o, EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o,
              EX_ALUSrc_o, EX_ALUOp_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o,
              EX_funct_o, EX_rs1_o, EX_rs2_o, EX_rd_o};
   endfunction

   task automatic rand_id();
      ID_valid_i    = 1'($urandom);
      ID_RegWrite_i = 1'($urandom);
      ID_MemtoReg_i = 1'($urandom);
      ID_MemRead_i  = 1'($urandom);
      ID_MemWrite_i = 1'($urandom);
      ID_ALUSrc_i   = 1'($urandom);
      ID_ALUOp_i    = 2'($urandom);
      ID_RS1data_i  = $urandom;
      ID_RS2data_i  = $urandom;
      ID_Imm_i      = $urandom;
      ID_funct_i    = 10'($urandom);
      ID_rs1_i      = 5'($urandom);
      ID_rs2_i      = 5'($urandom);
      ID_rd_i       = 5'($urandom | 1);
   endtask

   // Advance one clock; inputs are held stable from here to the edge.
   task automatic cycle();
      if (MemStall_i) begin
         m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      end else if (NoOp_i) begin
         m_ex  = '0;
         m_bub = (m_bub < CNT_MAX) ? m_bub + 1 : CNT_MAX;
      end else begin
         m_ex = id_vec();
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic model_reset();
      m_ex = '0;
      m_bub = 0;
      m_stall = 0;
   endtask

   task automatic test_reset();
      logic [VEC_W-1:0] got;
      rand_id();
      @(posedge clk_i);
      #3;
      rst_i = 1'b0;
      model_reset();
      #1;
      got = ex_vec();
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL reset_async_ex: got %h want 0", got);
      end
      repeat (2) begin
         rand_id();
         @(posedge clk_i);
         #1;
      end
      checks++;
      if (ex_vec() !== '0 || bubble_cnt_o !== '0 || stall_cnt_o !== '0) begin
         errors++;
         $display("FAIL reset_held: ex %h bub %0d stall %0d want all 0", ex_vec(), bubble_cnt_o, stall_cnt_o);
      end
      #2;
      rst_i = 1'b1;
      #1;
      rand_id();
      ID_rd_i = 5'd5;
      ID_RegWrite_i = 1'b1;
      cycle();
      checks++;
      if (EX_rd_o !== 5'd5 || EX_RegWrite_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_load: rd %0d regwrite %b want 5 1", EX_rd_o, EX_RegWrite_o);
      end
      checks++;
      if (ex_vec() !== m_ex) begin
         errors++;
         $display("FAIL reset_release_vec: got %h want %h", ex_vec(), m_ex);
      end
   endtask

   task automatic test_load_use();
      rand_id();
      ID_valid_i = 1'b1; ID_MemRead_i = 1'b1; ID_MemtoReg_i = 1'b1; ID_RegWrite_i = 1'b1;
      ID_MemWrite_i = 1'b0; ID_ALUSrc_i = 1'b1; ID_ALUOp_i = 2'b00; ID_rd_i = 5'd5;
      cycle();
      checks++;
      if (EX_MemRead_o !== 1'b1 || EX_rd_o !== 5'd5) begin
         errors++;
         $display("FAIL lw_in_ex: memread %b rd %0d want 1 5", EX_MemRead_o, EX_rd_o);
      end
      ID_MemRead_i = 1'b0; ID_MemtoReg_i = 1'b0; ID_ALUSrc_i = 1'b0; ID_ALUOp_i = 2'b10;
      ID_rs1_i = 5'd5; ID_rs2_i = 5'd1; ID_rd_i = 5'd6; ID_funct_i = '0;
      NoOp_i = 1'b1;
      cycle();
      checks++;
      if (EX_MemRead_o !== 1'b0 || EX_rd_o !== 5'd0 || EX_valid_o !== 1'b0 || bubble_cnt_o !== 16'd1) begin
         errors++;
         $display("FAIL bubble: memread %b rd %0d valid %b bub %0d want 0 0 0 1",
                  EX_MemRead_o, EX_rd_o, EX_valid_o, bubble_cnt_o);
      end
      checks++;
      if (ex_vec() !== '0) begin
         errors++;
         $display("FAIL bubble_all_zero: got %h want 0", ex_vec());
      end
      NoOp_i = 1'b0;
      cycle();
      checks++;
      if (EX_rd_o !== 5'd6 || EX_rs1_o !== 5'd5 || EX_valid_o !== 1'b1 || EX_ALUOp_o !== 2'b10) begin
         errors++;
         $display("FAIL add_after_bubble: rd %0d rs1 %0d valid %b aluop %b want 6 5 1 10",
                  EX_rd_o, EX_rs1_o, EX_valid_o, EX_ALUOp_o);
      end
   endtask

   task automatic test_cache_stall();
      logic [VEC_W-1:0] frozen;
      int unsigned      s0;
      frozen = ex_vec();
      s0 = stall_cnt_o;
      MemStall_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rand_id();
         NoOp_i = 1'($urandom);
         cycle();
         checks++;
         if (ex_vec() !== frozen) begin
            errors++;
            $display("FAIL stall_frozen[%0d]: got %h want %h", i, ex_vec(), frozen);
         end
      end
      checks++;
      if (int'(stall_cnt_o) - int'(s0) !== 4 || int'(stall_cnt_o) !== m_stall) begin
         errors++;
         $display("FAIL stall_count: got %0d want %0d", stall_cnt_o, s0 + 4);
      end
      MemStall_i = 1'b0;
      NoOp_i = 1'b0;
   endtask

   task automatic test_simultaneous();
      int unsigned s0, b0;
      logic [VEC_W-1:0] frozen;
      s0 = stall_cnt_o;
      b0 = bubble_cnt_o;
      frozen = ex_vec();
      MemStall_i = 1'b1;
      NoOp_i = 1'b1;
      repeat (2) begin
         rand_id();
         cycle();
      end
      checks++;
      if (ex_vec() !== frozen || bubble_cnt_o !== 16'(b0)) begin
         errors++;
         $display("FAIL simul_hold: ex %h bub %0d want %h %0d", ex_vec(), bubble_cnt_o, frozen, b0);
      end
      MemStall_i = 1'b0;
      cycle();
      checks++;
      if (ex_vec() !== '0 || stall_cnt_o !== 16'(s0 + 2) || bubble_cnt_o !== 16'(b0 + 1)) begin
         errors++;
         $display("FAIL simul_bubble: ex %h stall %0d bub %0d want 0 %0d %0d",
                  ex_vec(), stall_cnt_o, bubble_cnt_o, s0 + 2, b0 + 1);
      end
      NoOp_i = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rand_id();
         MemStall_i = ($urandom_range(0, 3) == 0);
         NoOp_i = ($urandom_range(0, 3) == 0);
         cycle();
         checks++;
         if (ex_vec() !== m_ex || int'(bubble_cnt_o) !== m_bub || int'(stall_cnt_o) !== m_stall) begin
            errors++;
            $display("FAIL random[%0d]: ex %h bub %0d stall %0d want %h %0d %0d",
                     i, ex_vec(), bubble_cnt_o, stall_cnt_o, m_ex, m_bub, m_stall);
         end
      end
      MemStall_i = 1'b0;
      NoOp_i = 1'b0;
   endtask

   task automatic test_saturation();
      #2;
      rst_i = 1'b0;
      model_reset();
      #2;
      rst_i = 1'b1;
      #1;
      NoOp_i = 1'b1;
      for (int i = 0; i < 65534; i++) begin
         rand_id();
         cycle();
      end
      checks++;
      if (bubble_cnt_o !== 16'hFFFE) begin
         errors++;
         $display("FAIL sat_below: got %h want fffe", bubble_cnt_o);
      end
      for (int i = 0; i < 3; i++) begin
         cycle();
      end
      checks++;
      if (bubble_cnt_o !== 16'hFFFF || int'(bubble_cnt_o) !== m_bub) begin
         errors++;
         $display("FAIL sat_65537: got %h want ffff", bubble_cnt_o);
      end
      repeat (5) cycle();
      checks++;
      if (bubble_cnt_o !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_hold: got %h want ffff", bubble_cnt_o);
      end
      NoOp_i = 1'b0;
   endtask

   task automatic test_mid_stall_reset();
      rand_id();
      cycle();
      MemStall_i = 1'b1;
      NoOp_i = 1'b1;
      repeat (2) cycle();
      #2;
      rst_i = 1'b0;
      model_reset();
      #1;
      checks++;
      if (ex_vec() !== '0 || bubble_cnt_o !== '0 || stall_cnt_o !== '0) begin
         errors++;
         $display("FAIL midstall_reset: ex %h bub %0d stall %0d want all 0", ex_vec(), bubble_cnt_o, stall_cnt_o);
      end
      #2;
      rst_i = 1'b1;
      MemStall_i = 1'b0;
      NoOp_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_id();
         cycle();
         checks++;
         if (ex_vec() !== m_ex || ex_vec() !== id_vec()) begin
            errors++;
            $display("FAIL resume_load[%0d]: got %h want %h", i, ex_vec(), m_ex);
         end
      end
      checks++;
      if (bubble_cnt_o !== '0 || stall_cnt_o !== '0) begin
         errors++;
         $display("FAIL resume_counts: bub %0d stall %0d want 0 0", bubble_cnt_o, stall_cnt_o);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_cache_stall();
      test_simultaneous();
      test_random();
      test_saturation();
      test_mid_stall_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
